ex_hazard_core: RTL and testbench



---
 rtl/ex_hazard_if.sv | 32 +++
 rtl/ex_hazard_core.sv | 107 ++++++++++
 tb/tb_ex_hazard_core.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_hazard_if.sv
// Execute-stage bus: E-stage operands/controls in, ALU/branch results,
// hazard controls and event counters out.
interface ex_hazard_if;
  logic [31:0] rd1E, rd2E, resultW, aluoutM, pcE, immE;
  logic [1:0]  alusrcAE, alusrcBE;
  logic [3:0]  alucontrolE;
  logic        jumpsrcE, branchE, inv_brE, jumpE, memtoregE;
  logic [4:0]  ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW;
  logic        regwriteM, regwriteW;
  logic [31:0] aluoutE, writedataE, pcbranchE, jmptargetE;
  logic        zeroE, pcsrcE, stallF, stallD, flushD, flushE;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] stall_count, flush_count;

  modport master (
    output rd1E, rd2E, resultW, aluoutM, pcE, immE, alusrcAE, alusrcBE,
           alucontrolE, jumpsrcE, branchE, inv_brE, jumpE, memtoregE,
           ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW, regwriteM, regwriteW,
    input  aluoutE, writedataE, pcbranchE, jmptargetE, zeroE, pcsrcE,
           stallF, stallD, flushD, flushE, forwardAE, forwardBE,
           stall_count, flush_count
  );

  modport slave (
    input  rd1E, rd2E, resultW, aluoutM, pcE, immE, alusrcAE, alusrcBE,
           alucontrolE, jumpsrcE, branchE, inv_brE, jumpE, memtoregE,
           ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW, regwriteM, regwriteW,
    output aluoutE, writedataE, pcbranchE, jmptargetE, zeroE, pcsrcE,
           stallF, stallD, flushD, flushE, forwardAE, forwardBE,
           stall_count, flush_count
  );
endinterface

// File: rtl/ex_hazard_core.sv
// Execute stage of the RV32I pipeline: forwarding, ALU, branch/jump targets,
// load-use stall / control flush generation and two event counters.
module ex_hazard_core (
  input  logic        clk,
  input  logic        reset,
  ex_hazard_if.slave  bus
);
  logic [4:0]  ra_e [2];
  logic [31:0] rd_e [2];
  logic [1:0]  fwd  [2];
  logic [31:0] opnd [2];

  logic [31:0] src_a, src_b, alu_result;
  logic [31:0] jump_base, jump_sum;
  logic        pcsrc, lwstall, control_change;
  logic [31:0] stall_count_reg, flush_count_reg;

  assign ra_e[0] = bus.ra1E;
  assign ra_e[1] = bus.ra2E;
  assign rd_e[0] = bus.rd1E;
  assign rd_e[1] = bus.rd2E;

  // M has priority over W; x0 is hard-wired zero and never forwarded.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] = (ra_e[gi] != 5'd0 && bus.regwriteM && ra_e[gi] == bus.rdM) ? 2'b10 :
                       (ra_e[gi] != 5'd0 && bus.regwriteW && ra_e[gi] == bus.rdW) ? 2'b01 :
                                                                                     2'b00;
      assign opnd[gi] = fwd[gi][1] ? bus.aluoutM :
                        fwd[gi][0] ? bus.resultW : rd_e[gi];
    end
  endgenerate

  always_comb begin
    src_a = 32'd0;
    case (bus.alusrcAE)
      2'b00:   src_a = opnd[0];
      2'b01:   src_a = bus.pcE;
      default: src_a = 32'd0;
    endcase
  end

  always_comb begin
    src_b = 32'd0;
    case (bus.alusrcBE)
      2'b00:   src_b = opnd[1];
      2'b01:   src_b = bus.immE;
      2'b10:   src_b = 32'd4;
      default: src_b = 32'd0;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (bus.alucontrolE)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a << src_b[4:0];
      4'b0011: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      4'b0100: alu_result = {31'd0, src_a < src_b};
      4'b0101: alu_result = src_a ^ src_b;
      4'b0110: alu_result = src_a >> src_b[4:0];
      4'b0111: alu_result = $unsigned($signed(src_a) >>> src_b[4:0]);
      4'b1000: alu_result = src_a | src_b;
      4'b1001: alu_result = src_a & src_b;
      4'b1010: alu_result = src_b;
      default: alu_result = 32'd0;
    endcase
  end

  assign bus.aluoutE    = alu_result;
  assign bus.zeroE      = (alu_result == 32'd0);
  assign bus.writedataE = opnd[1];
  assign bus.pcbranchE  = bus.pcE + bus.immE;
  assign bus.forwardAE  = fwd[0];
  assign bus.forwardBE  = fwd[1];

  // JALR base comes from the forwarded rs1; target LSB is always cleared.
  assign jump_base      = bus.jumpsrcE ? opnd[0] : bus.pcE;
  assign jump_sum       = jump_base + bus.immE;
  assign bus.jmptargetE = {jump_sum[31:1], 1'b0};

  assign pcsrc          = bus.branchE & ((alu_result == 32'd0) ^ bus.inv_brE);
  assign bus.pcsrcE     = pcsrc;
  assign control_change = pcsrc | bus.jumpE;
  assign lwstall        = bus.memtoregE && (bus.rdE != 5'd0) &&
                          (bus.rdE == bus.ra1D || bus.rdE == bus.ra2D);

  assign bus.stallF = lwstall & ~reset;
  assign bus.stallD = lwstall & ~reset;
  assign bus.flushD = control_change | reset;
  assign bus.flushE = lwstall | control_change | reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= 32'd0;
      flush_count_reg <= 32'd0;
    end else begin
      if (lwstall)        stall_count_reg <= stall_count_reg + 32'd1;
      if (control_change) flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign bus.stall_count = stall_count_reg;
  assign bus.flush_count = flush_count_reg;
endmodule

// File: tb/tb_ex_hazard_core.sv
// Randomised + directed scoreboard bench for ex_hazard_core.
module tb_ex_hazard_core;
  logic clk;
  logic reset;
  ex_hazard_if bus ();

  ex_hazard_core dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1E, rd2E, resultW, aluoutM, pcE, immE;
    logic [1:0]  asrc, bsrc;
    logic [3:0]  op;
    logic        jsrc, br, inv, jmp, mtr;
    logic [4:0]  ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW;
    logic        rwM, rwW, rst;
  } stim_t;

  typedef struct {
    logic [31:0] alu, wd, pcb, jt, sc, fc;
    logic        zero, pcsrc, sF, sD, fD, fE;
    logic [1:0]  fa, fb;
  } exp_t;

  exp_t        sb_q[$];
  logic        valid;
  int          errors;
  int          checks;
  logic [31:0] cnt_s, cnt_f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  // Reference model: evaluates the execute-stage rules directly.
  function automatic exp_t model(stim_t s, logic [31:0] sc, logic [31:0] fc);
    exp_t e;
    logic [31:0] a_reg, b_reg, a, b, r, base;
    int unsigned sh;
    logic lw, cc;
    e.fa = 2'd0; a_reg = s.rd1E;
    if (s.ra1E != 0 && s.rwM && s.ra1E == s.rdM) begin e.fa = 2'd2; a_reg = s.aluoutM; end
    else if (s.ra1E != 0 && s.rwW && s.ra1E == s.rdW) begin e.fa = 2'd1; a_reg = s.resultW; end
    e.fb = 2'd0; b_reg = s.rd2E;
    if (s.ra2E != 0 && s.rwM && s.ra2E == s.rdM) begin e.fb = 2'd2; b_reg = s.aluoutM; end
    else if (s.ra2E != 0 && s.rwW && s.ra2E == s.rdW) begin e.fb = 2'd1; b_reg = s.resultW; end
    if (s.asrc == 0) a = a_reg; else if (s.asrc == 1) a = s.pcE; else a = 0;
    if (s.bsrc == 0) b = b_reg; else if (s.bsrc == 1) b = s.immE; else if (s.bsrc == 2) b = 4; else b = 0;
    sh = b % 32;
    case (s.op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << sh;
      3:  r = (int'(a) < int'(b)) ? 1 : 0;
      4:  r = (a < b) ? 1 : 0;
      5:  r = a ^ b;
      6:  r = a >> sh;
      7:  r = 32'(int'(a) >>> sh);
      8:  r = a | b;
      9:  r = a & b;
      10: r = b;
      default: r = 0;
    endcase
    e.alu   = r;
    e.zero  = (r == 0);
    e.wd    = b_reg;
    e.pcb   = s.pcE + s.immE;
    base    = s.jsrc ? a_reg : s.pcE;
    e.jt    = (base + s.immE) & 32'hFFFF_FFFE;
    e.pcsrc = s.br && (e.zero != s.inv);
    cc      = e.pcsrc || s.jmp;
    lw      = s.mtr && s.rdE != 0 && (s.rdE == s.ra1D || s.rdE == s.ra2D);
    e.sF    = lw && !s.rst;
    e.sD    = e.sF;
    e.fD    = cc || s.rst;
    e.fE    = lw || cc || s.rst;
    e.sc    = sc;
    e.fc    = fc;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    bus.rd1E = s.rd1E; bus.rd2E = s.rd2E; bus.resultW = s.resultW; bus.aluoutM = s.aluoutM;
    bus.pcE = s.pcE; bus.immE = s.immE; bus.alusrcAE = s.asrc; bus.alusrcBE = s.bsrc;
    bus.alucontrolE = s.op; bus.jumpsrcE = s.jsrc; bus.branchE = s.br; bus.inv_brE = s.inv;
    bus.jumpE = s.jmp; bus.memtoregE = s.mtr; bus.ra1D = s.ra1D; bus.ra2D = s.ra2D;
    bus.ra1E = s.ra1E; bus.ra2E = s.ra2E; bus.rdE = s.rdE; bus.rdM = s.rdM; bus.rdW = s.rdW;
    bus.regwriteM = s.rwM; bus.regwriteW = s.rwW; reset = s.rst;
    e = model(s, cnt_s, cnt_f);
    sb_q.push_back(e);
    valid = 1'b1;
    // Counter view after the coming edge.
    if (s.rst) begin
      cnt_s = 0; cnt_f = 0;
    end else begin
      if (e.sF) cnt_s = cnt_s + 1;
      if (e.pcsrc || s.jmp) cnt_f = cnt_f + 1;
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '{rd1E: 0, rd2E: 0, resultW: 0, aluoutM: 0, pcE: 0, immE: 0, asrc: 0, bsrc: 0,
          op: 0, jsrc: 0, br: 0, inv: 0, jmp: 0, mtr: 0, ra1D: 0, ra2D: 0, ra1E: 0,
          ra2E: 0, rdE: 0, rdM: 0, rdW: 0, rwM: 0, rwW: 0, rst: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rd1E = $urandom; s.rd2E = $urandom; s.resultW = $urandom; s.aluoutM = $urandom;
    s.pcE = $urandom; s.immE = $urandom; s.asrc = 2'($urandom); s.bsrc = 2'($urandom);
    s.op = 4'($urandom); s.jsrc = 1'($urandom); s.br = 1'($urandom); s.inv = 1'($urandom);
    s.jmp = ($urandom_range(0, 3) == 0); s.mtr = 1'($urandom);
    s.ra1D = 5'($urandom_range(0, 3)); s.ra2D = 5'($urandom_range(0, 3));
    s.ra1E = 5'($urandom_range(0, 3)); s.ra2E = 5'($urandom_range(0, 3));
    s.rdE = 5'($urandom_range(0, 3)); s.rdM = 5'($urandom_range(0, 3));
    s.rdW = 5'($urandom_range(0, 3));
    s.rwM = 1'($urandom); s.rwW = 1'($urandom);
    s.rst = ($urandom_range(0, 24) == 0);
    if ($urandom_range(0, 3) == 0) s.rd2E = s.rd1E;
    return s;
  endfunction

  // Monitor: one comparison set per presented transaction.
  int txn_no;
  initial begin
    exp_t e;
    txn_no = 0;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (sb_q.size() == 0) begin
          chk("queue_underflow", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("aluoutE", bus.aluoutE, e.alu);
          chk("zeroE", 32'(bus.zeroE), 32'(e.zero));
          chk("writedataE", bus.writedataE, e.wd);
          chk("pcbranchE", bus.pcbranchE, e.pcb);
          chk("jmptargetE", bus.jmptargetE, e.jt);
          chk("pcsrcE", 32'(bus.pcsrcE), 32'(e.pcsrc));
          chk("stallF", 32'(bus.stallF), 32'(e.sF));
          chk("stallD", 32'(bus.stallD), 32'(e.sD));
          chk("flushD", 32'(bus.flushD), 32'(e.fD));
          chk("flushE", 32'(bus.flushE), 32'(e.fE));
          chk("forwardAE", 32'(bus.forwardAE), 32'(e.fa));
          chk("forwardBE", 32'(bus.forwardBE), 32'(e.fb));
          chk("stall_count", bus.stall_count, e.sc);
          chk("flush_count", bus.flush_count, e.fc);
          $display("txn %0d rst=%b alu=%h pcsrc=%b stallF=%b flushD=%b flushE=%b sc=%0d fc=%0d",
                   txn_no, reset, bus.aluoutE, bus.pcsrcE, bus.stallF, bus.flushD, bus.flushE,
                   bus.stall_count, bus.flush_count);
          txn_no++;
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [3:0] code;
    errors = 0; checks = 0; valid = 1'b0; cnt_s = 0; cnt_f = 0;
    s = quiet();
    reset = 1'b1;
    bus.rd1E = 0; bus.rd2E = 0; bus.resultW = 0; bus.aluoutM = 0; bus.pcE = 0; bus.immE = 0;
    bus.alusrcAE = 0; bus.alusrcBE = 0; bus.alucontrolE = 0; bus.jumpsrcE = 0; bus.branchE = 0;
    bus.inv_brE = 0; bus.jumpE = 0; bus.memtoregE = 0; bus.ra1D = 0; bus.ra2D = 0; bus.ra1E = 0;
    bus.ra2E = 0; bus.rdE = 0; bus.rdM = 0; bus.rdW = 0; bus.regwriteM = 0; bus.regwriteW = 0;
    repeat (2) @(posedge clk);

    // Reset level held: flushes asserted, stalls suppressed even with a load-use hazard.
    s = quiet(); s.rst = 1; s.mtr = 1; s.rdE = 7; s.ra2D = 7; apply(s);

    // ALU sweep over every code with a=FFFFFFF0, b=4.
    for (int i = 0; i < 16; i++) begin
      s = quiet(); s.rd1E = 32'hFFFF_FFF0; s.rd2E = 32'h4; code = 4'(i); s.op = code; apply(s);
    end
    s = quiet(); s.rd1E = 32'hFFFF_FFFF; s.rd2E = 1; apply(s);

    // Forwarding priority and x0.
    s = quiet(); s.ra1E = 5; s.rdM = 5; s.rwM = 1; s.rdW = 5; s.rwW = 1;
    s.aluoutM = 32'h1234; s.resultW = 32'h5678; s.rd1E = 32'h9; s.bsrc = 2'b11; apply(s);
    s.ra1E = 0; apply(s);
    s.ra2E = 5; s.rdM = 4; s.bsrc = 2'b00; s.op = 4'b1010; apply(s);

    // Load-use.
    s = quiet(); s.mtr = 1; s.rdE = 7; s.ra2D = 7; apply(s);
    s.rdE = 0; s.ra2D = 0; apply(s);

    // Branches and jumps.
    s = quiet(); s.rd1E = 3; s.rd2E = 3; s.op = 4'b0001; s.br = 1; s.inv = 1; apply(s);
    s.inv = 0; apply(s);
    s = quiet(); s.pcE = 32'h100; s.immE = 32'h20; apply(s);
    s = quiet(); s.jsrc = 1; s.jmp = 1; s.ra1E = 3; s.rdM = 3; s.rwM = 1;
    s.aluoutM = 32'h1003; s.immE = 2; apply(s);

    // Counters: clear, 3 stalls, 2 jumps, observe, then one reset cycle.
    s = quiet(); s.rst = 1; apply(s);
    s = quiet(); s.mtr = 1; s.rdE = 2; s.ra1D = 2;
    repeat (3) apply(s);
    s = quiet(); s.jmp = 1;
    repeat (2) apply(s);
    s = quiet(); apply(s);
    s = quiet(); s.rst = 1; s.jmp = 1; s.mtr = 1; s.rdE = 2; s.ra1D = 2; apply(s);
    s = quiet(); apply(s);

    for (int i = 0; i < 300; i++) apply(rand_stim());

    @(posedge clk);
    #1 valid = 1'b0;
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
